lb_timing_gen: RTL and testbench
================================

LB_TIMING_GEN -- requirements
Module: lb_timing_gen

Interface
REQ-001 Parameter: HOR_WIDTH, default `HOR_WIDTH, width of all horizontal timing fields and counters.
REQ-002 Parameter: VER_WIDTH, default `VER_WIDTH, width of all vertical timing fields and counters.
REQ-003 i_clk  in  1  single clock; all logic rising-edge.
REQ-004 i_rstn  in  1  asynchronous active-low reset.
REQ-005 i_en  in  1  run request; level-sensitive.
REQ-006 i_hsw / i_hbp / i_hact / i_hfp  in  HOR_WIDTH each  horizontal sync / back-porch / active / front-porch lengths, in clocks.
REQ-007 i_vsw / i_vbp / i_vact / i_vfp  in  VER_WIDTH each  vertical sync / back-porch / active / front-porch lengths, in lines.
REQ-008 o_vsync, o_hsync, o_de  out  1 each  active-high timing strobes driving the line-buffer datapath.
REQ-009 o_hpos  out  HOR_WIDTH  active pixel index; o_vpos  out  VER_WIDTH  active line index.
REQ-010 o_frame_start  out  1  one-cycle pulse on the first cycle of each frame.
REQ-011 o_busy  out  1  high from frame start until the generator returns to IDLE.

Function
REQ-012 States: IDLE, V_SYNC, V_BP, V_ACT, V_FP (vertical); H_SYNC, H_BP, H_ACT, H_FP (horizontal, active while not IDLE).
REQ-013 In IDLE with i_en sampled high: latch all eight timing inputs into shadow registers, then enter V_SYNC/H_SYNC on the next cycle.
REQ-014 All outputs registered; strobes valid on the first cycle spent in each state.
REQ-015 Line = hsw+hbp+hact+hfp clocks; frame = vsw+vbp+vact+vfp lines; counters use shadow values only.
REQ-016 A phase with length 0 is skipped; next phase entered with no idle cycle. hsw, hact, vsw, vact are never skipped (see REQ-027/028).
REQ-017 Vertical state advances only on the last clock of H_FP (or last clock of the last nonzero H phase).
REQ-018 o_hsync high during H_SYNC on every line, including blanking lines.
REQ-019 o_vsync high for all clocks of lines in V_SYNC; its edges coincide with the first H_SYNC clock of a line.
REQ-020 o_de high iff horizontal state H_ACT and vertical state V_ACT.
REQ-021 o_hpos counts 0..hact-1 during o_de, else 0; o_vpos counts 0..vact-1 through V_ACT lines, else 0.
REQ-022 o_frame_start pulses on the first V_SYNC/H_SYNC clock.
REQ-023 At the end of V_FP: i_en high -> re-latch shadows, start next frame with no gap; i_en low -> IDLE, o_busy low the next cycle.
REQ-024 i_en deassertion mid-frame does not truncate the frame; timing-input changes mid-frame take effect only at the next frame start.

Reset
REQ-025 i_rstn low asynchronously forces IDLE, clears shadows and counters, and drives all outputs to 0, including mid-frame.
REQ-026 After i_rstn release, the generator waits in IDLE for i_en; no output toggles until then.

Configuration
REQ-027 Macro LB_TG_CFG_CHK_EN defined: adds port o_cfg_err (out, 1). If any latched hsw, hact, vsw or vact is 0, the block stays in IDLE, holds o_busy low and sets o_cfg_err; o_cfg_err clears on the next latch with valid values or on reset.
REQ-028 LB_TG_CFG_CHK_EN undefined: no o_cfg_err port. A zero hsw, hact, vsw or vact is treated as length 1.

Verification
REQ-029 hsw=2,hbp=3,hact=8,hfp=4, vsw=1,vbp=2,vact=4,vfp=1, i_en held -> frame 136 clocks; o_de high 32 clocks in 4 runs of 8; o_vsync high 17 clocks; o_frame_start every 136 clocks.
REQ-030 Same timing, hbp=0, vfp=0 -> line 14 clocks, frame 7 lines = 98 clocks; o_de directly follows o_hsync fall.
REQ-031 Change hact 8->4 mid-frame -> current frame keeps 8-pixel lines; next frame 4-pixel lines (total 13 clocks per line).
REQ-032 Drop i_en at line 2 of frame -> frame completes all 136 clocks; o_busy falls the cycle after the last V_FP clock; no further o_frame_start.
REQ-033 Assert i_rstn low during V_ACT -> all outputs 0 immediately (asynchronously); after release with i_en high, new frame begins with o_frame_start.
REQ-034 With LB_TG_CFG_CHK_EN: hact=0 -> o_cfg_err=1, o_busy=0, no strobes. Without the macro: hact=0 -> one o_de clock per active line.

Source files
------------

// File: rtl/lb_timing_gen.sv
// Line-buffer video timing generator: sync/back-porch/active/front-porch sequencing in H and V.
// Define LB_TG_CFG_CHK_EN to add o_cfg_err and reject zero hsw/hact/vsw/vact instead of stretching them to 1.
`ifndef HOR_WIDTH
`define HOR_WIDTH 12
`endif
`ifndef VER_WIDTH
`define VER_WIDTH 11
`endif

module lb_timing_gen #(
    parameter int HOR_WIDTH = `HOR_WIDTH,
    parameter int VER_WIDTH = `VER_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic [HOR_WIDTH-1:0] i_hsw,
    input  logic [HOR_WIDTH-1:0] i_hbp,
    input  logic [HOR_WIDTH-1:0] i_hact,
    input  logic [HOR_WIDTH-1:0] i_hfp,
    input  logic [VER_WIDTH-1:0] i_vsw,
    input  logic [VER_WIDTH-1:0] i_vbp,
    input  logic [VER_WIDTH-1:0] i_vact,
    input  logic [VER_WIDTH-1:0] i_vfp,
    output logic                 o_vsync,
    output logic                 o_hsync,
    output logic                 o_de,
    output logic [HOR_WIDTH-1:0] o_hpos,
    output logic [VER_WIDTH-1:0] o_vpos,
    output logic                 o_frame_start,
    output logic                 o_busy
`ifdef LB_TG_CFG_CHK_EN
   ,output logic                 o_cfg_err
`endif
);

    localparam logic [2:0] V_IDLE = 3'd0;
    localparam logic [2:0] V_SYNC = 3'd1;
    localparam logic [2:0] V_BP   = 3'd2;
    localparam logic [2:0] V_ACT  = 3'd3;
    localparam logic [2:0] V_FP   = 3'd4;

    localparam logic [1:0] H_SYNC = 2'd0;
    localparam logic [1:0] H_BP   = 2'd1;
    localparam logic [1:0] H_ACT  = 2'd2;
    localparam logic [1:0] H_FP   = 2'd3;

    localparam logic [HOR_WIDTH-1:0] H_ONE = HOR_WIDTH'(1);
    localparam logic [VER_WIDTH-1:0] V_ONE = VER_WIDTH'(1);

    // Mandatory phases: without the checker a zero length runs as one unit.
    function automatic logic [HOR_WIDTH-1:0] h_len(input logic [HOR_WIDTH-1:0] x);
`ifdef LB_TG_CFG_CHK_EN
        return x;
`else
        return (x == '0) ? H_ONE : x;
`endif
    endfunction

    function automatic logic [VER_WIDTH-1:0] v_len(input logic [VER_WIDTH-1:0] x);
`ifdef LB_TG_CFG_CHK_EN
        return x;
`else
        return (x == '0) ? V_ONE : x;
`endif
    endfunction

    logic [2:0]           v_state, v_nxt;
    logic [1:0]           h_state, h_nxt;
    logic [HOR_WIDTH-1:0] h_cnt, h_cnt_nxt;
    logic [VER_WIDTH-1:0] v_cnt, v_cnt_nxt;
    logic                 arm, arm_nxt;
    logic                 latch, start;
    logic                 line_end, last_line, frame_end;
    logic [HOR_WIDTH-1:0] start_hsw;
    logic [VER_WIDTH-1:0] start_vsw;
    logic                 sh_ok, in_ok;
    logic                 run_nxt, de_nxt;

    logic [HOR_WIDTH-1:0] sh_hsw, sh_hbp, sh_hact, sh_hfp;
    logic [VER_WIDTH-1:0] sh_vsw, sh_vbp, sh_vact, sh_vfp;

`ifdef LB_TG_CFG_CHK_EN
    assign sh_ok = (sh_hsw != '0) && (sh_hact != '0) && (sh_vsw != '0) && (sh_vact != '0);
    assign in_ok = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0);
`else
    assign sh_ok = 1'b1;
    assign in_ok = 1'b1;
`endif

    // Counters hold the remaining clocks/lines of the current phase minus one.
    always_comb begin
        v_nxt     = v_state;
        h_nxt     = h_state;
        h_cnt_nxt = h_cnt;
        v_cnt_nxt = v_cnt;
        arm_nxt   = 1'b0;
        latch     = 1'b0;
        start     = 1'b0;
        start_hsw = sh_hsw;
        start_vsw = sh_vsw;
        line_end  = ((h_state == H_FP) || ((h_state == H_ACT) && (sh_hfp == '0))) && (h_cnt == '0);
        last_line = ((v_state == V_FP) || ((v_state == V_ACT) && (sh_vfp == '0))) && (v_cnt == '0);
        frame_end = (v_state != V_IDLE) && line_end && last_line;

        if (v_state == V_IDLE) begin
            if (arm) begin
                start = sh_ok;
            end else if (i_en) begin
                latch   = 1'b1;
                arm_nxt = 1'b1;
            end
        end else begin
            if (h_cnt != '0) begin
                h_cnt_nxt = h_cnt - H_ONE;
            end else begin
                case (h_state)
                    H_SYNC: begin
                        if (sh_hbp != '0) begin
                            h_nxt     = H_BP;
                            h_cnt_nxt = sh_hbp - H_ONE;
                        end else begin
                            h_nxt     = H_ACT;
                            h_cnt_nxt = sh_hact - H_ONE;
                        end
                    end
                    H_BP: begin
                        h_nxt     = H_ACT;
                        h_cnt_nxt = sh_hact - H_ONE;
                    end
                    H_ACT: begin
                        if (sh_hfp != '0) begin
                            h_nxt     = H_FP;
                            h_cnt_nxt = sh_hfp - H_ONE;
                        end else begin
                            h_nxt     = H_SYNC;
                            h_cnt_nxt = sh_hsw - H_ONE;
                        end
                    end
                    default: begin
                        h_nxt     = H_SYNC;
                        h_cnt_nxt = sh_hsw - H_ONE;
                    end
                endcase
            end

            if (line_end) begin
                if (v_cnt != '0) begin
                    v_cnt_nxt = v_cnt - V_ONE;
                end else begin
                    case (v_state)
                        V_SYNC: begin
                            if (sh_vbp != '0) begin
                                v_nxt     = V_BP;
                                v_cnt_nxt = sh_vbp - V_ONE;
                            end else begin
                                v_nxt     = V_ACT;
                                v_cnt_nxt = sh_vact - V_ONE;
                            end
                        end
                        V_BP: begin
                            v_nxt     = V_ACT;
                            v_cnt_nxt = sh_vact - V_ONE;
                        end
                        V_ACT: begin
                            if (sh_vfp != '0) begin
                                v_nxt     = V_FP;
                                v_cnt_nxt = sh_vfp - V_ONE;
                            end
                        end
                        default: v_nxt = V_IDLE;
                    endcase
                end
            end

            // Back-to-back frames load the first phase straight from the inputs being latched.
            if (frame_end) begin
                v_nxt = V_IDLE;
                if (i_en) begin
                    latch     = 1'b1;
                    start     = in_ok;
                    start_hsw = h_len(i_hsw);
                    start_vsw = v_len(i_vsw);
                end
            end
        end

        if (start) begin
            v_nxt     = V_SYNC;
            h_nxt     = H_SYNC;
            h_cnt_nxt = start_hsw - H_ONE;
            v_cnt_nxt = start_vsw - V_ONE;
        end
    end

    assign run_nxt = (v_nxt != V_IDLE);
    assign de_nxt  = (v_nxt == V_ACT) && (h_nxt == H_ACT);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v_state <= V_IDLE;
            h_state <= H_SYNC;
            h_cnt   <= '0;
            v_cnt   <= '0;
            arm     <= 1'b0;
            sh_hsw  <= '0;
            sh_hbp  <= '0;
            sh_hact <= '0;
            sh_hfp  <= '0;
            sh_vsw  <= '0;
            sh_vbp  <= '0;
            sh_vact <= '0;
            sh_vfp  <= '0;
        end else begin
            v_state <= v_nxt;
            h_state <= h_nxt;
            h_cnt   <= h_cnt_nxt;
            v_cnt   <= v_cnt_nxt;
            arm     <= arm_nxt;
            if (latch) begin
                sh_hsw  <= h_len(i_hsw);
                sh_hbp  <= i_hbp;
                sh_hact <= h_len(i_hact);
                sh_hfp  <= i_hfp;
                sh_vsw  <= v_len(i_vsw);
                sh_vbp  <= i_vbp;
                sh_vact <= v_len(i_vact);
                sh_vfp  <= i_vfp;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_vsync       <= 1'b0;
            o_hsync       <= 1'b0;
            o_de          <= 1'b0;
            o_hpos        <= '0;
            o_vpos        <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_vsync       <= (v_nxt == V_SYNC);
            o_hsync       <= run_nxt && (h_nxt == H_SYNC);
            o_de          <= de_nxt;
            o_hpos        <= (de_nxt && o_de) ? o_hpos + H_ONE : '0;
            o_frame_start <= start;
            o_busy        <= run_nxt;
            if ((v_nxt == V_ACT) && (v_state == V_ACT))
                o_vpos <= line_end ? o_vpos + V_ONE : o_vpos;
            else
                o_vpos <= '0;
        end
    end

`ifdef LB_TG_CFG_CHK_EN
    logic cfg_rej;
    logic cfg_err;

    assign cfg_rej = ((v_state == V_IDLE) && arm && !sh_ok) || (frame_end && i_en && !in_ok);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            cfg_err <= 1'b0;
        else if (start)
            cfg_err <= 1'b0;
        else if (cfg_rej)
            cfg_err <= 1'b1;
    end

    assign o_cfg_err = cfg_err;
`endif

endmodule

// File: tb/tb_lb_timing_gen.sv
// Bench for lb_timing_gen: vector table, corner-case sequences and randomized frames against
// an arithmetic (position-in-frame) model of the timing.
`timescale 1ns/1ps

module tb_lb_timing_gen;

    localparam int HW = 10;
    localparam int VW = 8;

    localparam int ACT_NONE = 0;
    localparam int ACT_CFG  = 1;
    localparam int ACT_DROP = 2;
    localparam int ACT_RST  = 3;

    typedef struct packed {
        logic [HW-1:0] hsw, hbp, hact, hfp;
        logic [VW-1:0] vsw, vbp, vact, vfp;
    } cfg_t;

    typedef struct packed {
        logic          vsync, hsync, de, fs, busy;
        logic [HW-1:0] hpos;
        logic [VW-1:0] vpos;
    } obs_t;

    typedef struct {
        cfg_t cfg;
        int   period;
        int   de_cnt;
        int   vs_cnt;
    } vec_t;

    logic          i_clk, i_rstn, i_en;
    logic [HW-1:0] i_hsw, i_hbp, i_hact, i_hfp;
    logic [VW-1:0] i_vsw, i_vbp, i_vact, i_vfp;
    logic          o_vsync, o_hsync, o_de, o_frame_start, o_busy;
    logic [HW-1:0] o_hpos;
    logic [VW-1:0] o_vpos;
`ifdef LB_TG_CFG_CHK_EN
    logic          o_cfg_err;
`endif

    int n_checks, n_errors;
    int seen_de, seen_vs;

    lb_timing_gen #(.HOR_WIDTH(HW), .VER_WIDTH(VW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en),
        .i_hsw(i_hsw), .i_hbp(i_hbp), .i_hact(i_hact), .i_hfp(i_hfp),
        .i_vsw(i_vsw), .i_vbp(i_vbp), .i_vact(i_vact), .i_vfp(i_vfp),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_hpos(o_hpos), .o_vpos(o_vpos),
        .o_frame_start(o_frame_start), .o_busy(o_busy)
`ifdef LB_TG_CFG_CHK_EN
       ,.o_cfg_err(o_cfg_err)
`endif
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic apply_reset();
        i_en   = 1'b0;
        i_rstn = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int line_len(input cfg_t c);
        return eff(int'(c.hsw)) + int'(c.hbp) + eff(int'(c.hact)) + int'(c.hfp);
    endfunction

    function automatic int frame_len(input cfg_t c);
        return line_len(c) * (eff(int'(c.vsw)) + int'(c.vbp) + eff(int'(c.vact)) + int'(c.vfp));
    endfunction

    function automatic obs_t model(input cfg_t c, input int t);
        obs_t r;
        int   l, ln, x, hs, hb, ha, vs, vb, va;
        logic h_on, v_on;
        hs = eff(int'(c.hsw));  hb = int'(c.hbp);  ha = eff(int'(c.hact));
        vs = eff(int'(c.vsw));  vb = int'(c.vbp);  va = eff(int'(c.vact));
        l  = line_len(c);
        ln = t / l;
        x  = t % l;
        h_on    = (x >= hs + hb) && (x < hs + hb + ha);
        v_on    = (ln >= vs + vb) && (ln < vs + vb + va);
        r.vsync = (ln < vs);
        r.hsync = (x < hs);
        r.de    = h_on && v_on;
        r.fs    = (t == 0);
        r.busy  = 1'b1;
        r.hpos  = r.de ? HW'(x - hs - hb) : '0;
        r.vpos  = v_on ? VW'(ln - vs - vb) : '0;
        return r;
    endfunction

    function automatic obs_t cur();
        obs_t r;
        r.vsync = o_vsync;
        r.hsync = o_hsync;
        r.de    = o_de;
        r.fs    = o_frame_start;
        r.busy  = o_busy;
        r.hpos  = o_hpos;
        r.vpos  = o_vpos;
        return r;
    endfunction

    function automatic cfg_t mk(input int hsw, hbp, hact, hfp, vsw, vbp, vact, vfp);
        cfg_t c;
        c.hsw = HW'(hsw);  c.hbp = HW'(hbp);  c.hact = HW'(hact);  c.hfp = HW'(hfp);
        c.vsw = VW'(vsw);  c.vbp = VW'(vbp);  c.vact = VW'(vact);  c.vfp = VW'(vfp);
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        int lo;
`ifdef LB_TG_CFG_CHK_EN
        lo = 1;
`else
        lo = 0;
`endif
        return mk($urandom_range(3, lo), $urandom_range(3, 0), $urandom_range(6, lo), $urandom_range(3, 0),
                  $urandom_range(2, lo), $urandom_range(2, 0), $urandom_range(4, lo), $urandom_range(2, 0));
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cfg(input cfg_t c);
        i_hsw = c.hsw;  i_hbp = c.hbp;  i_hact = c.hact;  i_hfp = c.hfp;
        i_vsw = c.vsw;  i_vbp = c.vbp;  i_vact = c.vact;  i_vfp = c.vfp;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic count_quiet(input int cycles, output int bad);
        bad = 0;
        repeat (cycles) begin
            @(negedge i_clk);
            if (cur() != '0) bad++;
        end
    endtask

    // Checks one whole frame cycle by cycle; optionally acts on the inputs at cycle act_t.
    task automatic run_frame(input cfg_t c, input bit wait_start, input int act, input int act_t,
                             input cfg_t nc);
        int f, n;
        f       = frame_len(c);
        seen_de = 0;
        seen_vs = 0;
        if (wait_start) begin
            n = 0;
            do begin
                @(negedge i_clk);
                n++;
            end while (!o_frame_start && n < 2000);
            chk("frame_start_wait", 64'(o_frame_start), 64'(1));
            if (!o_frame_start) return;
        end else begin
            @(negedge i_clk);
        end
        for (int t = 0; t < f; t++) begin
            if (t > 0) @(negedge i_clk);
            chk($sformatf("frame_t%0d", t), 64'(cur()), 64'(model(c, t)));
            seen_de += int'(o_de);
            seen_vs += int'(o_vsync);
            if (t == act_t) begin
                if (act == ACT_CFG) drive_cfg(nc);
                if (act == ACT_DROP) i_en = 1'b0;
                if (act == ACT_RST) begin
                    #1 i_rstn = 1'b0;
                    #1 chk("async_reset_outputs", 64'(cur()), 64'(0));
                    return;
                end
            end
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[5];
    int   nvec;
    cfg_t cfg0, cfg31, c, nc;
    int   bad, cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cfg0  = mk(2, 3, 8, 4, 1, 2, 4, 1);
        cfg31 = mk(2, 3, 4, 4, 1, 2, 4, 1);

        tbl[0].cfg = cfg0;                         tbl[0].period = 136; tbl[0].de_cnt = 32; tbl[0].vs_cnt = 17;
        tbl[1].cfg = mk(2, 0, 8, 4, 1, 2, 4, 0);   tbl[1].period = 98;  tbl[1].de_cnt = 32; tbl[1].vs_cnt = 14;
        tbl[2].cfg = cfg31;                        tbl[2].period = 104; tbl[2].de_cnt = 16; tbl[2].vs_cnt = 13;
        tbl[3].cfg = mk(1, 0, 1, 0, 1, 0, 1, 0);   tbl[3].period = 4;   tbl[3].de_cnt = 1;  tbl[3].vs_cnt = 2;
        tbl[4].cfg = mk(2, 3, 0, 4, 1, 2, 4, 1);   tbl[4].period = 80;  tbl[4].de_cnt = 4;  tbl[4].vs_cnt = 10;
`ifdef LB_TG_CFG_CHK_EN
        nvec = 4;
`else
        nvec = 5;
`endif

        // reset state and quiet idle
        i_rstn = 1'b0;
        i_en   = 1'b0;
        drive_cfg(cfg0);
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", 64'(cur()), 64'(0));
        i_rstn = 1'b1;
        count_quiet(20, bad);
        chk("idle_quiet_after_reset", 64'(bad), 64'(0));

        // table-driven frames
        for (int i = 0; i < nvec; i++) begin
            apply_reset();
            drive_cfg(tbl[i].cfg);
            i_en = 1'b1;
            run_frame(tbl[i].cfg, 1'b1, ACT_NONE, -1, tbl[i].cfg);
            chk($sformatf("vec%0d_de_count", i), 64'(seen_de), 64'(tbl[i].de_cnt));
            chk($sformatf("vec%0d_vsync_count", i), 64'(seen_vs), 64'(tbl[i].vs_cnt));
            @(negedge i_clk);
            chk($sformatf("vec%0d_next_start", i), 64'(o_frame_start), 64'(1));
            cnt = 0;
            do begin
                @(negedge i_clk);
                cnt++;
            end while (!o_frame_start && cnt < 1000);
            chk($sformatf("vec%0d_period", i), 64'(cnt), 64'(tbl[i].period));
        end

        // timing change mid-frame applies only to the next frame
        apply_reset();
        drive_cfg(cfg0);
        i_en = 1'b1;
        run_frame(cfg0, 1'b1, ACT_CFG, 20, cfg31);
        chk("midframe_change_de_count", 64'(seen_de), 64'(32));
        run_frame(cfg31, 1'b0, ACT_NONE, -1, cfg31);
        chk("next_frame_de_count", 64'(seen_de), 64'(16));

        // enable dropped on line 2: frame completes, then idle
        apply_reset();
        drive_cfg(cfg0);
        i_en = 1'b1;
        run_frame(cfg0, 1'b1, ACT_DROP, 34, cfg0);
        @(negedge i_clk);
        chk("busy_after_last_fp", 64'(o_busy), 64'(0));
        chk("no_start_after_drop", 64'(o_frame_start), 64'(0));
        count_quiet(40, bad);
        chk("quiet_after_drop", 64'(bad), 64'(0));

        // asynchronous reset during V_ACT, then restart
        apply_reset();
        drive_cfg(cfg0);
        i_en = 1'b1;
        run_frame(cfg0, 1'b1, ACT_RST, 75, cfg0);
        count_quiet(3, bad);
        chk("held_in_reset", 64'(bad), 64'(0));
        i_rstn = 1'b1;
        run_frame(cfg0, 1'b1, ACT_NONE, -1, cfg0);

`ifdef LB_TG_CFG_CHK_EN
        apply_reset();
        drive_cfg(mk(2, 3, 0, 4, 1, 2, 4, 1));
        i_en = 1'b1;
        bad  = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_busy || o_hsync || o_vsync || o_de || o_frame_start) bad++;
        end
        chk("cfg_err_set", 64'(o_cfg_err), 64'(1));
        chk("cfg_err_no_strobes", 64'(bad), 64'(0));
        drive_cfg(cfg0);
        run_frame(cfg0, 1'b1, ACT_NONE, -1, cfg0);
        chk("cfg_err_cleared", 64'(o_cfg_err), 64'(0));
`endif

        // randomized back-to-back frames with a mid-frame reprogram each frame
        apply_reset();
        c = rand_cfg();
        drive_cfg(c);
        i_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            nc = rand_cfg();
            run_frame(c, (k == 0), ACT_CFG, $urandom_range(frame_len(c) - 1, 0), nc);
            c = nc;
        end
        apply_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
